// File: rtl/vx_raster_tile_split.sv
// vx_raster_tile_split: splits one raster tile into four half-size quadrants.
// Each quadrant that overlaps all three edges is emitted with re-evaluated edges.
// Ports:
//   clk, reset (async, active-low)
//   valid_in/ready_in + pid_in, xloc_in, yloc_in, edges_in, extents_in : tile in
//   valid_out/ready_out + pid_out, xloc_out, yloc_out, edges_out,
//   extents_out : quadrant out
//   busy : split in progress or output pending
module vx_raster_tile_split #(
  parameter int DATA_BITS    = 32,
  parameter int TILE_LOGSIZE = 5,
  parameter int POS_BITS     = 16,
  parameter int PID_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               valid_in,
  output logic                               ready_in,
  input  logic [PID_BITS-1:0]                pid_in,
  input  logic [POS_BITS-1:0]                xloc_in,
  input  logic [POS_BITS-1:0]                yloc_in,
  input  logic [2:0][2:0][DATA_BITS-1:0]     edges_in,
  input  logic [2:0][DATA_BITS-1:0]          extents_in,
  output logic                               valid_out,
  input  logic                               ready_out,
  output logic [PID_BITS-1:0]                pid_out,
  output logic [POS_BITS-1:0]                xloc_out,
  output logic [POS_BITS-1:0]                yloc_out,
  output logic [2:0][2:0][DATA_BITS-1:0]     edges_out,
  output logic [2:0][DATA_BITS-1:0]          extents_out,
  output logic                               busy
);

  localparam int SH = TILE_LOGSIZE - 1;
  localparam logic [POS_BITS-1:0] HALF =
    POS_BITS'(1) << SH;

  typedef enum logic {
    IDLE,
    SPLIT
  } state_e;

  state_e state_q, state_d;
  logic [1:0] q_q, q_d;

  logic [PID_BITS-1:0]            pid_q;
  logic [POS_BITS-1:0]            xloc_q;
  logic [POS_BITS-1:0]            yloc_q;
  logic [2:0][2:0][DATA_BITS-1:0] edges_q;
  logic [2:0][DATA_BITS-1:0]      ext_q;

  logic                           vout_q;
  logic [PID_BITS-1:0]            pid_out_q;
  logic [POS_BITS-1:0]            xloc_out_q;
  logic [POS_BITS-1:0]            yloc_out_q;
  logic [2:0][2:0][DATA_BITS-1:0] edges_out_q;
  logic [2:0][DATA_BITS-1:0]      ext_out_q;

  logic [2:0][DATA_BITS-1:0] eq_w;
  logic [2:0][DATA_BITS-1:0] sub_w;
  logic [2:0][DATA_BITS-1:0] sum_w;
  logic                      ovl_w;
  logic                      adv_w;
  logic                      accept_w;
  logic [POS_BITS-1:0]       qxloc_w;
  logic [POS_BITS-1:0]       qyloc_w;

  // Quadrant edge evaluation and trivial reject.
  // A zero sum (quadrant corner exactly on the edge) counts as overlap.
  always_comb begin
    eq_w  = '0;
    sub_w = '0;
    sum_w = '0;
    ovl_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eq_w[i] = edges_q[i][2]
              + (q_q[0] ? (edges_q[i][0] << SH) : '0)
              + (q_q[1] ? (edges_q[i][1] << SH) : '0);
      sub_w[i] = ext_q[i] >> 1;
      sum_w[i] = eq_w[i] + sub_w[i];
      ovl_w = ovl_w & ~sum_w[i][DATA_BITS-1];
    end
    qxloc_w = xloc_q + (q_q[0] ? HALF : '0);
    qyloc_w = yloc_q + (q_q[1] ? HALF : '0);
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    ready_in = 1'b0;
    accept_w = 1'b0;
    adv_w    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_in = 1'b1;
        if (valid_in) begin
          accept_w = 1'b1;
          q_d      = 2'd0;
          state_d  = SPLIT;
        end
      end
      SPLIT: begin
        adv_w = ~vout_q | ready_out;
        if (adv_w) begin
          q_d = q_q + 2'd1;
          if (q_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pid_q   <= '0;
      xloc_q  <= '0;
      yloc_q  <= '0;
      edges_q <= '0;
      ext_q   <= '0;
    end else if (accept_w) begin
      pid_q   <= pid_in;
      xloc_q  <= xloc_in;
      yloc_q  <= yloc_in;
      edges_q <= edges_in;
      ext_q   <= extents_in;
    end
  end

  // Output register: rejected quadrants only drop valid if the
  // current output is consumed; data is kept otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vout_q      <= 1'b0;
      pid_out_q   <= '0;
      xloc_out_q  <= '0;
      yloc_out_q  <= '0;
      edges_out_q <= '0;
      ext_out_q   <= '0;
    end else if (adv_w && ovl_w) begin
      vout_q     <= 1'b1;
      pid_out_q  <= pid_q;
      xloc_out_q <= qxloc_w;
      yloc_out_q <= qyloc_w;
      ext_out_q  <= sub_w;
      for (int i = 0; i < 3; i++) begin
        edges_out_q[i] <= {eq_w[i], edges_q[i][1], edges_q[i][0]};
      end
    end else begin
      vout_q <= vout_q & ~ready_out;
    end
  end

  assign valid_out   = vout_q;
  assign pid_out     = pid_out_q;
  assign xloc_out    = xloc_out_q;
  assign yloc_out    = yloc_out_q;
  assign edges_out   = edges_out_q;
  assign extents_out = ext_out_q;
  assign busy        = (state_q == SPLIT) | vout_q;

endmodule

// File: tb/tb_vx_raster_tile_split.sv
// Directed bench for vx_raster_tile_split.
// Outputs sampled on the falling edge; inputs driven there too.
module tb_vx_raster_tile_split;

  logic                      clk;
  logic                      reset;
  logic                      valid_in;
  logic                      ready_in;
  logic [7:0]                pid_in;
  logic [15:0]               xloc_in;
  logic [15:0]               yloc_in;
  logic [2:0][2:0][31:0]     edges_in;
  logic [2:0][31:0]          extents_in;
  logic                      valid_out;
  logic                      ready_out;
  logic [7:0]                pid_out;
  logic [15:0]               xloc_out;
  logic [15:0]               yloc_out;
  logic [2:0][2:0][31:0]     edges_out;
  logic [2:0][31:0]          extents_out;
  logic                      busy;

  int n_cmp;
  int n_err;

  vx_raster_tile_split #(
    .DATA_BITS(32),
    .TILE_LOGSIZE(5),
    .POS_BITS(16),
    .PID_BITS(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .valid_in(valid_in),
    .ready_in(ready_in),
    .pid_in(pid_in),
    .xloc_in(xloc_in),
    .yloc_in(yloc_in),
    .edges_in(edges_in),
    .extents_in(extents_in),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .pid_out(pid_out),
    .xloc_out(xloc_out),
    .yloc_out(yloc_out),
    .edges_out(edges_out),
    .extents_out(extents_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tile(input logic [7:0] pid,
                          input logic [15:0] x,
                          input logic [15:0] y,
                          input logic [31:0] a0,
                          input logic [31:0] b0,
                          input logic [31:0] c0,
                          input logic [31:0] x0);
    pid_in  = pid;
    xloc_in = x;
    yloc_in = y;
    edges_in[0][0] = a0;
    edges_in[0][1] = b0;
    edges_in[0][2] = c0;
    extents_in[0]  = x0;
    for (int i = 1; i < 3; i++) begin
      edges_in[i][0] = 32'd0;
      edges_in[i][1] = 32'd0;
      edges_in[i][2] = 32'd1000;
      extents_in[i]  = 32'd0;
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [7:0] pid,
                         input logic [15:0] x,
                         input logic [15:0] y,
                         input logic [31:0] a0,
                         input logic [31:0] e0,
                         input logic [31:0] x0);
    chk({tag, "_v"}, valid_out, 1'b1);
    chk({tag, "_pid"}, pid_out, pid);
    chk({tag, "_x"}, xloc_out, x);
    chk({tag, "_y"}, yloc_out, y);
    chk({tag, "_a0"}, edges_out[0][0], a0);
    chk({tag, "_e0"}, edges_out[0][2], e0);
    chk({tag, "_e1"}, edges_out[1][2], 32'd1000);
    chk({tag, "_x0"}, extents_out[0], x0);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    set_tile(8'h00, 16'd0, 16'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", ready_in, 1'b1);
    chk("rst_x", xloc_out, 16'd0);
    chk("rst_e", edges_out[0][2], 32'd0);
    reset = 1'b1;

    // S1: four quadrants, no backpressure
    @(negedge clk);
    set_tile(8'h11, 16'd64, 16'd32, 32'd1, 32'd0, 32'd0, 32'd32);
    valid_in = 1'b1;
    chk("s1_rdy0", ready_in, 1'b1);
    @(negedge clk);
    valid_in = 1'b0;
    chk("s1_v_early", valid_out, 1'b0);
    chk("s1_busy", busy, 1'b1);
    chk("s1_rdy1", ready_in, 1'b0);
    @(negedge clk);
    chk_out("s1q0", 8'h11, 16'd64, 16'd32, 32'd1, 32'd0, 32'd16);
    @(negedge clk);
    chk_out("s1q1", 8'h11, 16'd80, 16'd32, 32'd1, 32'd16, 32'd16);
    @(negedge clk);
    chk_out("s1q2", 8'h11, 16'd64, 16'd48, 32'd1, 32'd0, 32'd16);
    @(negedge clk);
    chk_out("s1q3", 8'h11, 16'd80, 16'd48, 32'd1, 32'd16, 32'd16);
    chk("s1_rdy_back", ready_in, 1'b1);
    @(negedge clk);
    chk("s1_v_end", valid_out, 1'b0);
    chk("s1_busy_end", busy, 1'b0);

    // S2: negative a, odd quadrants rejected
    set_tile(8'h22, 16'd64, 16'd32, 32'hFFFF_FFFF, 32'd0, 32'd10, 32'd0);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    chk("s2_v_early", valid_out, 1'b0);
    @(negedge clk);
    chk_out("s2q0", 8'h22, 16'd64, 16'd32, 32'hFFFF_FFFF, 32'd10, 32'd0);
    @(negedge clk);
    chk("s2q1_rej", valid_out, 1'b0);
    @(negedge clk);
    chk_out("s2q2", 8'h22, 16'd64, 16'd48, 32'hFFFF_FFFF, 32'd10, 32'd0);
    chk("s2_rdy4", ready_in, 1'b0);
    @(negedge clk);
    chk("s2q3_rej", valid_out, 1'b0);
    chk("s2_rdy5", ready_in, 1'b1);

    // S3: all quadrants rejected
    set_tile(8'h33, 16'd64, 16'd32, 32'd0, 32'd0, 32'hFFFF_FF9C, 32'd0);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("s3_busy", busy, 1'b1);
      chk("s3_v", valid_out, 1'b0);
      @(negedge clk);
    end
    chk("s3_busy_end", busy, 1'b0);
    chk("s3_rdy", ready_in, 1'b1);
    chk("s3_v_end", valid_out, 1'b0);

    // S4: backpressure after the first output
    set_tile(8'h44, 16'd64, 16'd32, 32'd1, 32'd0, 32'd0, 32'd32);
    ready_out = 1'b0;
    valid_in  = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    chk_out("s4q0", 8'h44, 16'd64, 16'd32, 32'd1, 32'd0, 32'd16);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("s4_hold_v", valid_out, 1'b1);
      chk("s4_hold_x", xloc_out, 16'd64);
      chk("s4_hold_e", edges_out[0][2], 32'd0);
    end
    chk("s4_hold_rdy", ready_in, 1'b0);
    ready_out = 1'b1;
    @(negedge clk);
    chk_out("s4q1", 8'h44, 16'd80, 16'd32, 32'd1, 32'd16, 32'd16);
    @(negedge clk);
    chk_out("s4q2", 8'h44, 16'd64, 16'd48, 32'd1, 32'd0, 32'd16);
    @(negedge clk);
    chk_out("s4q3", 8'h44, 16'd80, 16'd48, 32'd1, 32'd16, 32'd16);
    @(negedge clk);
    chk("s4_v_end", valid_out, 1'b0);

    // S5: asynchronous reset after two outputs
    set_tile(8'h55, 16'd64, 16'd32, 32'd1, 32'd0, 32'd0, 32'd32);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    chk_out("s5q0", 8'h55, 16'd64, 16'd32, 32'd1, 32'd0, 32'd16);
    @(negedge clk);
    chk_out("s5q1", 8'h55, 16'd80, 16'd32, 32'd1, 32'd16, 32'd16);
    reset = 1'b0;
    #1;
    chk("s5_rst_v", valid_out, 1'b0);
    chk("s5_rst_x", xloc_out, 16'd0);
    chk("s5_rst_pid", pid_out, 8'd0);
    chk("s5_rst_e", edges_out[0][2], 32'd0);
    chk("s5_rst_ext", extents_out[0], 32'd0);
    chk("s5_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s5_after_v", valid_out, 1'b0);
      chk("s5_after_rdy", ready_in, 1'b1);
    end

    // S6: sum exactly zero still overlaps
    set_tile(8'h66, 16'd64, 16'd32, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'd32);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    chk_out("s6q0", 8'h66, 16'd64, 16'd32, 32'd0, 32'hFFFF_FFF0, 32'd16);
    @(negedge clk);
    chk_out("s6q1", 8'h66, 16'd80, 16'd32, 32'd0, 32'hFFFF_FFF0, 32'd16);
    @(negedge clk);
    chk_out("s6q2", 8'h66, 16'd64, 16'd48, 32'd0, 32'hFFFF_FFF0, 32'd16);
    @(negedge clk);
    chk_out("s6q3", 8'h66, 16'd80, 16'd48, 32'd0, 32'hFFFF_FFF0, 32'd16);
    @(negedge clk);
    chk("s6_v_end", valid_out, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
